note_judge: RTL and testbench

//  Hit-judgement and scoring stage directly downstream of the note shifter.

---
 rtl/note_judge_if.sv | 36 +++
 rtl/note_judge.sv | 160 ++++++++++++++++
 tb/tb_note_judge.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_judge_if.sv
// Handshake bundle between the note shifter, the player buttons and the
// judge stage: shifter/button inputs in, pulses and counters out.
interface note_judge_if;
  logic        red_button;
  logic        blue_button;
  logic        note_R_judge;
  logic        note_B_judge;
  logic [2:0]  offset;
  logic        start;
  logic        finish;
  logic        clear;
  logic        delete;
  logic        hit_perfect;
  logic        hit_good;
  logic        miss;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic [15:0] score;
  logic        busy;

  modport master (
    output red_button, blue_button,
    output note_R_judge, note_B_judge,
    output offset, start, finish, clear,
    input  delete, hit_perfect, hit_good, miss,
    input  combo, max_combo, score, busy
  );

  modport slave (
    input  red_button, blue_button,
    input  note_R_judge, note_B_judge,
    input  offset, start, finish, clear,
    output delete, hit_perfect, hit_good, miss,
    output combo, max_combo, score, busy
  );
endinterface

// File: rtl/note_judge.sv
// Hit judgement and scoring: debounces the player buttons, grades notes at
// the judge column and keeps combo, max combo and score for the display.
module note_judge #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PERFECT_PTS     = 3,
  parameter int GOOD_PTS        = 1,
  parameter int PERF_LO         = 2,
  parameter int PERF_HI         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  note_judge_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]  LO  = 3'(PERF_LO);
  localparam logic [2:0]  HI  = 3'(PERF_HI);
  localparam logic [16:0] PP  = 17'(PERFECT_PTS);
  localparam logic [16:0] GP  = 17'(GOOD_PTS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [1:0]    r_s1, r_s2, r_stb, r_stb_q;
  logic [CW-1:0] r_cnt [2];
  logic [1:0]    w_btn, w_press;

  state_t      r_state;
  logic [2:0]  r_off_q;
  logic        r_note_q, r_start_q, r_judged;
  logic        r_del, r_perf, r_good, r_miss, r_busy;
  logic [7:0]  r_combo, r_max;
  logic [15:0] r_score;

  logic        w_adv, w_miss_adv, w_judged, w_note;
  logic        w_match, w_hit, w_wrong, w_perf;
  logic [7:0]  w_combo0, w_combo, w_max;
  logic [16:0] w_pts, w_sum;
  logic [15:0] w_score;

  assign w_btn = {bus.blue_button, bus.red_button};

  // Index 0 is red, 1 is blue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_stb   <= '0;
      r_stb_q <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_s1    <= w_btn;
      r_s2    <= r_s1;
      r_stb_q <= r_stb;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_stb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_MAX) begin
          r_stb[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press = r_stb & ~r_stb_q;

  assign w_adv      = (bus.offset == 3'd0) && (r_off_q == 3'd6);
  assign w_miss_adv = w_adv & r_note_q & ~r_judged;
  assign w_judged   = r_judged & ~w_adv;
  assign w_note     = bus.note_R_judge | bus.note_B_judge;
  assign w_match    = (w_press[0] & bus.note_R_judge)
                    | (w_press[1] & bus.note_B_judge);
  assign w_hit      = ~w_judged & w_match;
  assign w_wrong    = ~w_judged & w_note & (|w_press) & ~w_match;
  assign w_perf     = w_hit & (bus.offset >= LO) & (bus.offset <= HI);

  // A miss on advance lands before a same-cycle hit, so combo ends at 1.
  assign w_combo0 = (w_miss_adv | w_wrong) ? 8'd0 : r_combo;
  assign w_combo  = !w_hit ? w_combo0
                  : (w_combo0 == 8'hFF) ? 8'hFF : w_combo0 + 8'd1;
  assign w_max    = (w_combo > r_max) ? w_combo : r_max;
  assign w_pts    = !w_hit ? 17'd0 : (w_perf ? PP : GP);
  assign w_sum    = {1'b0, r_score} + w_pts;
  assign w_score  = w_sum[16] ? 16'hFFFF : w_sum[15:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_off_q   <= '0;
      r_note_q  <= 1'b0;
      r_start_q <= 1'b0;
      r_judged  <= 1'b0;
      r_del     <= 1'b0;
      r_perf    <= 1'b0;
      r_good    <= 1'b0;
      r_miss    <= 1'b0;
      r_busy    <= 1'b0;
      r_combo   <= '0;
      r_max     <= '0;
      r_score   <= '0;
    end else begin
      r_off_q   <= bus.offset;
      r_note_q  <= w_note;
      r_start_q <= bus.start;
      r_del     <= 1'b0;
      r_perf    <= 1'b0;
      r_good    <= 1'b0;
      r_miss    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start && !r_start_q) begin
            r_state  <= S_PLAY;
            r_busy   <= 1'b1;
            r_combo  <= '0;
            r_max    <= '0;
            r_score  <= '0;
            r_judged <= 1'b0;
          end
        end
        S_PLAY: begin
          if (bus.finish) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
          end else begin
            r_del    <= w_hit | w_wrong;
            r_perf   <= w_perf;
            r_good   <= w_hit & ~w_perf;
            r_miss   <= w_miss_adv | w_wrong;
            r_combo  <= w_combo;
            r_max    <= w_max;
            r_score  <= w_score;
            r_judged <= w_judged | w_hit | w_wrong;
          end
        end
        S_DONE: begin
          if (bus.clear) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.delete      = r_del;
  assign bus.hit_perfect = r_perf;
  assign bus.hit_good    = r_good;
  assign bus.miss        = r_miss;
  assign bus.combo       = r_combo;
  assign bus.max_combo   = r_max;
  assign bus.score       = r_score;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_note_judge.sv
// Scoreboard bench for note_judge: expected pulse/counter snapshots are
// queued when a press or column advance is driven and popped on output.
module tb_note_judge;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  note_judge_if u_if ();

  note_judge #(
    .DEBOUNCE_CYCLES(4),
    .PERFECT_PTS(3),
    .GOOD_PTS(1),
    .PERF_LO(2),
    .PERF_HI(4)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(u_if)
  );

  typedef struct packed {
    logic        del;
    logic        perf;
    logic        good;
    logic        miss;
    logic [7:0]  combo;
    logic [7:0]  maxc;
    logic [15:0] score;
  } exp_t;

  exp_t sb[$];
  int n_run = 0;
  int n_fail = 0;
  int m_combo, m_max, m_score;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit del, input bit perf, input bit good,
                      input bit mis);
    exp_t e;
    e.del   = del;
    e.perf  = perf;
    e.good  = good;
    e.miss  = mis;
    e.combo = 8'(m_combo);
    e.maxc  = 8'(m_max);
    e.score = 16'(m_score);
    sb.push_back(e);
  endtask

  task automatic exp_hit(input bit perf);
    m_combo = (m_combo == 255) ? 255 : m_combo + 1;
    m_score = m_score + (perf ? 3 : 1);
    if (m_score > 65535) m_score = 65535;
    if (m_combo > m_max) m_max = m_combo;
    push(1'b1, perf, !perf, 1'b0);
  endtask

  task automatic exp_miss(input bit del);
    m_combo = 0;
    push(del, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic model_clear();
    m_combo = 0;
    m_max   = 0;
    m_score = 0;
  endtask

  task automatic press(input bit blue);
    if (blue) u_if.blue_button = 1'b1;
    else      u_if.red_button  = 1'b1;
    tick(8);
    u_if.blue_button = 1'b0;
    u_if.red_button  = 1'b0;
    tick(8);
  endtask

  task automatic drain(input int cyc);
    int k = 0;
    while (sb.size() != 0 && k < cyc) begin
      tick(1);
      k++;
    end
    chk("drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic adv_col();
    u_if.offset = 3'd6;
    tick(1);
    u_if.offset = 3'd0;
    tick(1);
  endtask

  task automatic pulse(input int which);
    case (which)
      0: u_if.start  = 1'b1;
      1: u_if.finish = 1'b1;
      default: u_if.clear = 1'b1;
    endcase
    tick(2);
    u_if.start  = 1'b0;
    u_if.finish = 1'b0;
    u_if.clear  = 1'b0;
    tick(2);
  endtask

  task automatic chk_regs(input bit busy);
    chk("combo", u_if.combo, m_combo);
    chk("max_combo", u_if.max_combo, m_max);
    chk("score", u_if.score, m_score);
    chk("busy", u_if.busy, busy);
  endtask

  task automatic chk_zero();
    chk("rst_del", u_if.delete, 0);
    chk("rst_perf", u_if.hit_perfect, 0);
    chk("rst_good", u_if.hit_good, 0);
    chk("rst_miss", u_if.miss, 0);
    chk("rst_combo", u_if.combo, 0);
    chk("rst_max", u_if.max_combo, 0);
    chk("rst_score", u_if.score, 0);
    chk("rst_busy", u_if.busy, 0);
  endtask

  task automatic do_hits(input int n);
    for (int i = 0; i < n; i++) begin
      u_if.offset = 3'd3;
      tick(1);
      exp_hit(1'b1);
      press(1'b0);
      drain(30);
      adv_col();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (u_if.delete | u_if.hit_perfect | u_if.hit_good
                  | u_if.miss)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse",
            {u_if.delete, u_if.hit_perfect, u_if.hit_good, u_if.miss}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("delete", u_if.delete, e.del);
        chk("hit_perfect", u_if.hit_perfect, e.perf);
        chk("hit_good", u_if.hit_good, e.good);
        chk("miss", u_if.miss, e.miss);
        chk("combo_ev", u_if.combo, e.combo);
        chk("max_ev", u_if.max_combo, e.maxc);
        chk("score_ev", u_if.score, e.score);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    u_if.red_button   = 1'b0;
    u_if.blue_button  = 1'b0;
    u_if.note_R_judge = 1'b0;
    u_if.note_B_judge = 1'b0;
    u_if.offset       = 3'd0;
    u_if.start        = 1'b0;
    u_if.finish       = 1'b0;
    u_if.clear        = 1'b0;
    model_clear();
    tick(3);
    chk_zero();
    rst_n = 1'b1;
    tick(2);
    pulse(0);
    chk_regs(1'b1);

    // T1 perfect red hit
    u_if.note_R_judge = 1'b1;
    u_if.offset = 3'd3;
    tick(1);
    exp_hit(1'b1);
    press(1'b0);
    drain(30);
    chk_regs(1'b1);
    adv_col();

    // T2 good blue hit at offset 6, second press ignored
    u_if.note_R_judge = 1'b0;
    u_if.note_B_judge = 1'b1;
    u_if.offset = 3'd6;
    tick(1);
    exp_hit(1'b0);
    press(1'b1);
    drain(30);
    press(1'b1);
    tick(4);
    chk_regs(1'b1);
    adv_col();

    // T3 combo up to 5, then an unjudged note rolls past
    u_if.note_B_judge = 1'b0;
    u_if.note_R_judge = 1'b1;
    do_hits(3);
    chk_regs(1'b1);
    u_if.offset = 3'd3;
    tick(2);
    u_if.offset = 3'd6;
    tick(1);
    exp_miss(1'b0);
    u_if.offset = 3'd0;
    u_if.note_R_judge = 1'b0;
    tick(1);
    drain(10);
    chk_regs(1'b1);

    // T4 glitch rejected, wrong colour is a miss with delete
    u_if.offset = 3'd3;
    u_if.note_R_judge = 1'b1;
    tick(2);
    u_if.red_button = 1'b1;
    tick(2);
    u_if.red_button = 1'b0;
    tick(12);
    chk_regs(1'b1);
    exp_miss(1'b1);
    press(1'b1);
    drain(30);
    chk_regs(1'b1);
    u_if.note_R_judge = 1'b0;
    tick(2);

    pulse(1);
    chk_regs(1'b0);
    pulse(0);
    chk_regs(1'b0);
    pulse(2);
    pulse(0);
    model_clear();
    chk_regs(1'b1);

    // T5 combo saturation, then score saturation
    u_if.note_R_judge = 1'b1;
    do_hits(300);
    chk_regs(1'b1);
    @(negedge clk);
    force u_dut.r_score = 16'hFFFE;
    @(posedge clk);
    #1;
    release u_dut.r_score;
    m_score = 16'hFFFE;
    tick(1);
    chk("preload", u_if.score, m_score);
    do_hits(2);
    chk_regs(1'b1);

    // T6 reset mid-song, restart, DONE->IDLE via clear
    pulse(1);
    pulse(2);
    pulse(0);
    model_clear();
    do_hits(7);
    chk("combo7", u_if.combo, 7);
    rst_n = 1'b0;
    tick(1);
    chk_zero();
    rst_n = 1'b1;
    u_if.note_R_judge = 1'b0;
    model_clear();
    tick(2);
    chk_regs(1'b0);
    pulse(0);
    chk_regs(1'b1);
    pulse(1);
    chk_regs(1'b0);
    pulse(2);
    pulse(0);
    chk_regs(1'b1);
    pulse(1);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
